expmul_folded: RTL and testbench

//   Lane-folded, parametrised exponent-multiply unit for the online-softmax datapath.
//   Per transaction it scales two star vectors by 2^((x-m)*log2e), i.e. e^(x-m):
//     exp_v_out = v_star * e^(s-m)   and   exp_o_out = o_star_prev * e^(m_prev-m).
//   DIM elements are processed LANES per cycle through a shared multiplier bank.

---
 rtl/expmul_folded.sv | 173 +++++++++++++++++
 tb/tb_expmul_folded.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expmul_folded.sv
// Scales v_star by e^(s-m) and o_star_prev by e^(m_prev-m), LANES elements per beat over NB beats.
// vld_out rises NB+1 edges after accept; results hold while vld_out && !rdy_in, and rdy_out follows the output handshake.
module expmul_folded #(
    parameter int DIM    = 65,
    parameter int LANES  = 8,
    parameter int SC_W   = 9,
    parameter int VEC_W  = 27,
    parameter int EXP_FR = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vld_in,
    output logic                 rdy_out,
    output logic                 vld_out,
    input  logic                 rdy_in,
    input  logic                 auto_max_in,
    input  logic                 first_in,
    input  logic [SC_W-1:0]      m_in,
    input  logic [SC_W-1:0]      m_prev_in,
    input  logic [SC_W-1:0]      s_in,
    input  logic [DIM*VEC_W-1:0] o_star_prev_in,
    input  logic [DIM*VEC_W-1:0] v_star_in,
    output logic [DIM*VEC_W-1:0] exp_o_out,
    output logic [DIM*VEC_W-1:0] exp_v_out,
    output logic [SC_W-1:0]      m_out,
    output logic                 ovf_out
);
    localparam int NB = (DIM + LANES - 1) / LANES;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int DW = SC_W + 1;
    localparam int TW = DW + 16;
    localparam int TF = 18;
    localparam int RW = EXP_FR + 1;
    localparam int SW = EXP_FR + 2;
    localparam int CW = RW + (TF - 6) + 16;
    localparam int PW = VEC_W + SW + 2;
    localparam logic signed [TW-1:0] LOG2E = TW'(23637);
    localparam logic [15:0]          LN2   = 16'd45426;

    typedef enum logic [1:0] {IDLE, PREP, STREAM, DONE} state_t;

    state_t                  state, state_nx;
    logic [BW-1:0]           beat;
    logic                    accept;
    logic                    am_r, first_r;
    logic signed [SC_W-1:0]  m_r, mp_r, s_r, m_sel;
    logic [DIM*VEC_W-1:0]    o_r, v_r;
    logic [SW-1:0]           sc_v, sc_o;
    logic [7:0]              sh_v, sh_o;
    logic [VEC_W-1:0]        lane_v [LANES];
    logic [VEC_W-1:0]        lane_o [LANES];
    logic [64*RW-1:0]        rom;

    // 2^(i/64) in Q1.EXP_FR, folded to constants at elaboration
    for (genvar g = 0; g < 64; g++) begin : g_rom
        assign rom[g*RW +: RW] = RW'($rtoi(2.0 ** (real'(g) / 64.0) * (2.0 ** EXP_FR) + 0.5));
    end

    always_comb begin
        m_sel = m_r;
        if (am_r)
            m_sel = (s_r > mp_r) ? s_r : mp_r;
    end

    // path 0: x = s (v-path); path 1: x = m_prev (o-path)
    for (genvar p = 0; p < 2; p++) begin : g_path
        logic signed [SC_W-1:0] x;
        logic signed [DW-1:0]   d;
        logic signed [TW-1:0]   t;
        logic [RW-1:0]          rv;
        logic [CW-1:0]          corr;
        logic [SW-1:0]          scale;
        logic [7:0]             sh;
        logic                   ovf;
        assign x = (p == 0) ? s_r : mp_r;
        always_comb begin
            d     = DW'(x) - DW'(m_sel);
            ovf   = (d > 0);
            if (ovf)
                d = '0;
            t     = TW'(d) * LOG2E;
            rv    = rom[t[TF-1 -: 6]*RW +: RW];
            corr  = CW'(rv) * CW'(t[TF-7:0]) * CW'(LN2);
            scale = SW'(rv) + SW'(corr >> (TF + 16));
            sh    = 8'(EXP_FR) - 8'($signed(t[TW-1:TF]));
        end
    end

    function automatic int lane_idx(input logic [BW-1:0] b, input int l);
        int i;
        i = int'(b) * LANES + l;
        return (i < DIM) ? i : 0;
    endfunction

    function automatic logic [VEC_W-1:0] scale_elem(input logic [VEC_W-1:0] e,
                                                    input logic [SW-1:0] sc,
                                                    input logic [7:0] sh);
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] rnd;
        prod = PW'($signed(e)) * $signed(PW'({1'b0, sc}));
        rnd  = PW'(1) << (sh - 8'd1);
        prod = (prod + rnd) >>> sh;
        return (sh >= 8'(VEC_W + EXP_FR)) ? '0 : prod[VEC_W-1:0];
    endfunction

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_v[l] = scale_elem(v_r[lane_idx(beat, l)*VEC_W +: VEC_W], sc_v, sh_v);
            lane_o[l] = first_r ? '0 : scale_elem(o_r[lane_idx(beat, l)*VEC_W +: VEC_W], sc_o, sh_o);
        end
    end

    always_comb begin
        state_nx = state;
        rdy_out  = rst_n && ((state == IDLE) || (state == DONE && rdy_in));
        vld_out  = (state == DONE);
        accept   = vld_in && rdy_out;
        case (state)
            IDLE:    if (accept) state_nx = PREP;
            PREP:    state_nx = STREAM;
            STREAM:  if (beat == BW'(NB - 1)) state_nx = DONE;
            DONE:    if (rdy_in) state_nx = accept ? PREP : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            am_r    <= auto_max_in;
            first_r <= first_in;
            m_r     <= m_in;
            mp_r    <= m_prev_in;
            s_r     <= s_in;
            o_r     <= o_star_prev_in;
            v_r     <= v_star_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            sc_v      <= '0;
            sc_o      <= '0;
            sh_v      <= '0;
            sh_o      <= '0;
            m_out     <= '0;
            ovf_out   <= 1'b0;
            exp_v_out <= '0;
            exp_o_out <= '0;
        end else begin
            state <= state_nx;
            if (state == PREP) begin
                beat    <= '0;
                sc_v    <= g_path[0].scale;
                sh_v    <= g_path[0].sh;
                sc_o    <= g_path[1].scale;
                sh_o    <= g_path[1].sh;
                m_out   <= m_sel;
                ovf_out <= g_path[0].ovf | g_path[1].ovf;
            end
            if (state == STREAM) begin
                beat <= beat + 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    if (int'(beat) * LANES + l < DIM) begin
                        exp_v_out[(int'(beat)*LANES + l)*VEC_W +: VEC_W] <= lane_v[l];
                        exp_o_out[(int'(beat)*LANES + l)*VEC_W +: VEC_W] <= lane_o[l];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_expmul_folded.sv
// Directed bench for expmul_folded: exact d=0 cases, e^-1 / e^-2 scaling, clamp, underflow, backpressure, mid-stream reset.
module tb_expmul_folded;
    localparam int DIM   = 65;
    localparam int LANES = 8;
    localparam int SC_W  = 9;
    localparam int VEC_W = 27;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic vld_in = 1'b0, rdy_out, vld_out, rdy_in = 1'b0;
    logic auto_max_in = 1'b0, first_in = 1'b0;
    logic [SC_W-1:0] m_in = '0, m_prev_in = '0, s_in = '0, m_out;
    logic [DIM*VEC_W-1:0] o_star_prev_in = '0, v_star_in = '0, exp_o_out, exp_v_out;
    logic ovf_out;

    int checks = 0;
    int errors = 0;
    int va [DIM];
    int oa [DIM];
    int lat;
    logic [DIM*VEC_W-1:0] snap_v, snap_o;
    logic [SC_W-1:0] snap_m;
    logic snap_ovf;

    always #5 clk = ~clk;

    expmul_folded #(.DIM(DIM), .LANES(LANES), .SC_W(SC_W), .VEC_W(VEC_W), .EXP_FR(16)) dut (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_out(rdy_out), .vld_out(vld_out),
        .rdy_in(rdy_in), .auto_max_in(auto_max_in), .first_in(first_in), .m_in(m_in),
        .m_prev_in(m_prev_in), .s_in(s_in), .o_star_prev_in(o_star_prev_in),
        .v_star_in(v_star_in), .exp_o_out(exp_o_out), .exp_v_out(exp_v_out),
        .m_out(m_out), .ovf_out(ovf_out)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
        checks++;
        assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, tol);
        end
    endtask

    function automatic int ev(input int i);
        return int'($signed(exp_v_out[i*VEC_W +: VEC_W]));
    endfunction

    function automatic int eo(input int i);
        return int'($signed(exp_o_out[i*VEC_W +: VEC_W]));
    endfunction

    function automatic int mism_v();
        int n = 0;
        for (int i = 0; i < DIM; i++) if (ev(i) != va[i]) n++;
        return n;
    endfunction

    function automatic int mism_o();
        int n = 0;
        for (int i = 0; i < DIM; i++) if (eo(i) != oa[i]) n++;
        return n;
    endfunction

    function automatic int nz_v();
        int n = 0;
        for (int i = 0; i < DIM; i++) if (ev(i) != 0) n++;
        return n;
    endfunction

    function automatic int nz_o();
        int n = 0;
        for (int i = 0; i < DIM; i++) if (eo(i) != 0) n++;
        return n;
    endfunction

    task automatic pack_vecs();
        for (int i = 0; i < DIM; i++) begin
            v_star_in[i*VEC_W +: VEC_W]      = VEC_W'(va[i]);
            o_star_prev_in[i*VEC_W +: VEC_W] = VEC_W'(oa[i]);
        end
    endtask

    task automatic set_ctl(input logic am, input logic fi, input logic [SC_W-1:0] mi,
                           input logic [SC_W-1:0] mp, input logic [SC_W-1:0] s);
        auto_max_in = am;
        first_in    = fi;
        m_in        = mi;
        m_prev_in   = mp;
        s_in        = s;
    endtask

    // Drives one accept, then scrambles every input to show they were captured.
    task automatic accept_txn(input string tag);
        int n = 0;
        @(negedge clk);
        pack_vecs();
        vld_in = 1'b1;
        while (!rdy_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " rdy_out"}, rdy_out, 1);
        @(posedge clk);
        #1;
        vld_in         = 1'b0;
        v_star_in      = ~v_star_in;
        o_star_prev_in = ~o_star_prev_in;
        m_in           = ~m_in;
        m_prev_in      = ~m_prev_in;
        s_in           = ~s_in;
        auto_max_in    = ~auto_max_in;
        first_in       = ~first_in;
    endtask

    task automatic wait_done(input string tag);
        lat = 0;
        while (!vld_out && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, lat, 10);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        rdy_in = 1'b1;
        @(posedge clk);
        #1;
        rdy_in = 1'b0;
        chk({tag, " vld_out after drain"}, vld_out, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #20;
        chk("rst vld_out", vld_out, 0);
        chk("rst rdy_out", rdy_out, 0);
        chk("rst m_out", m_out, 0);
        chk("rst ovf", ovf_out, 0);
        chk("rst outputs zero", (exp_v_out == '0) && (exp_o_out == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // d = 0 on both paths: outputs equal inputs exactly
        for (int i = 0; i < DIM; i++) begin
            va[i] = i * 1237 - 40000;
            oa[i] = 50000 - i * 911;
        end
        va[1] = 32768;
        oa[1] = 32768;
        set_ctl(1'b0, 1'b0, 9'h020, 9'h020, 9'h020);
        accept_txn("t1");
        wait_done("t1");
        chk("t1 m_out", m_out, 9'h020);
        chk("t1 ovf", ovf_out, 0);
        chk("t1 exp_v[1]", ev(1), 32768);
        chk("t1 exp_o[1]", eo(1), 32768);
        chk("t1 exp_v all", mism_v(), 0);
        chk("t1 exp_o all", mism_o(), 0);
        drain("t1");

        // s - m = -1.0: v scaled by e^-1, o untouched
        va[2] = -32768;
        set_ctl(1'b0, 1'b0, 9'h020, 9'h020, 9'h010);
        accept_txn("t2");
        wait_done("t2");
        chk_near("t2 exp_v[1]", ev(1), 12055, 1);
        chk_near("t2 exp_v[2]", ev(2), -12055, 1);
        chk("t2 exp_o all", mism_o(), 0);
        chk("t2 ovf", ovf_out, 0);
        drain("t2");

        // auto max picks s; o scaled by e^-2
        for (int i = 0; i < DIM; i++) oa[i] = 100000;
        set_ctl(1'b1, 1'b0, 9'h000, 9'h030, 9'h050);
        accept_txn("t3");
        wait_done("t3");
        chk("t3 m_out", m_out, 9'h050);
        chk("t3 exp_v all", mism_v(), 0);
        chk_near("t3 exp_o[0]", eo(0), 13534, 1);
        chk_near("t3 exp_o[64]", eo(64), 13534, 1);
        drain("t3");

        // first tile zeroes the o-path
        set_ctl(1'b1, 1'b1, 9'h000, 9'h030, 9'h050);
        accept_txn("t4");
        wait_done("t4");
        chk("t4 exp_o nonzero count", nz_o(), 0);
        chk("t4 exp_v all", mism_v(), 0);
        drain("t4");

        // s above external max: clamp, ovf, v unscaled
        oa[1] = 32768;
        set_ctl(1'b0, 1'b0, 9'h020, 9'h010, 9'h040);
        accept_txn("t5");
        wait_done("t5");
        chk("t5 ovf", ovf_out, 1);
        chk("t5 m_out", m_out, 9'h020);
        chk("t5 exp_v all", mism_v(), 0);
        chk_near("t5 exp_o[1]", eo(1), 12055, 1);
        drain("t5");

        // extreme negative exponent underflows v to zero; then hold under backpressure
        set_ctl(1'b1, 1'b0, 9'h000, 9'h0FF, 9'h100);
        accept_txn("t6");
        wait_done("t6");
        chk("t6 m_out", m_out, 9'h0FF);
        chk("t6 exp_v nonzero count", nz_v(), 0);
        chk("t6 exp_o all", mism_o(), 0);
        snap_v   = exp_v_out;
        snap_o   = exp_o_out;
        snap_m   = m_out;
        snap_ovf = ovf_out;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t6 hold", (rdy_out == 1'b0) && (vld_out == 1'b1) && (exp_v_out == snap_v) &&
                (exp_o_out == snap_o) && (m_out == snap_m) && (ovf_out == snap_ovf), 1);
        end

        // release and accept on the same edge
        for (int i = 0; i < DIM; i++) begin
            va[i] = 3 * i - 100;
            oa[i] = -7 * i;
        end
        set_ctl(1'b0, 1'b0, 9'h020, 9'h020, 9'h020);
        pack_vecs();
        vld_in = 1'b1;
        rdy_in = 1'b1;
        #1;
        chk("t7 b2b rdy_out", rdy_out, 1);
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        rdy_in = 1'b0;
        chk("t7 vld_out dropped", vld_out, 0);
        wait_done("t7");
        chk("t7 exp_v all", mism_v(), 0);
        chk("t7 exp_o all", mism_o(), 0);
        drain("t7");

        // reset during beat 4
        for (int i = 0; i < DIM; i++) begin
            va[i] = -(i * 5000) - 17;
            oa[i] = i * 4000 + 1;
        end
        set_ctl(1'b0, 1'b0, 9'h020, 9'h020, 9'h020);
        accept_txn("t8");
        repeat (5) @(posedge clk);
        #1;
        chk("t8 beat0 written", ev(0), -17);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t8 rst vld_out", vld_out, 0);
        chk("t8 rst rdy_out", rdy_out, 0);
        chk("t8 rst outputs zero", (exp_v_out == '0) && (exp_o_out == '0) && (m_out == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < DIM; i++) begin
            va[i] = i * 2222 - 77777;
            oa[i] = 12345 - i * 3;
        end
        set_ctl(1'b0, 1'b0, 9'h1F0, 9'h1F0, 9'h1F0);
        accept_txn("t9");
        wait_done("t9");
        chk("t9 m_out", m_out, 9'h1F0);
        chk("t9 exp_v all", mism_v(), 0);
        chk("t9 exp_o all", mism_o(), 0);
        drain("t9");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
